ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Parametrised multi-cycle control sequencer for the processor datapath. It fetches an instruction over an acknowledge handshake and decodes an opcode plus register field. It drives one-hot register write/increment/reset enables, ALU op, bus select and PC control. It also waits on data-memory acknowledge. Beyond a fixed-width control unit it adds:
- parametrised register count and instruction width
- acknowledge timeout with a sticky fault
- a HALT state
- an explicit PC/register init cycle

## Interface
Parameters:
- INS_W, 8, instruction width; opcode = ins[INS_W-1:INS_W-4], register field = ins[REG_W-1:0].
- NREG, 14, number of datapath registers; width of all enable vectors.
- REG_W, $clog2(NREG), register-field / bus-select width.
- ACK_TIMEOUT, 16, max cycles waiting for iacq/dacq; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ins  in  INS_W  instruction from instruction memory, captured when iacq high in FETCH.
- iacq  in  1  instruction-memory acknowledge.
- dacq  in  1  data-memory acknowledge.
- z1, z2  in  1  ALU zero flags, sampled in EXEC.
- imem_rd  out  1  instruction read request.
- dmem_rd, dmem_wr  out  1  data read / write request.
- alu_op  out  3  ALU operation.
- bus_sel  out  REG_W  register driven onto the bus.
- pc_ctrl  out  2  00 hold, 01 increment, 10 load branch target, 11 reset.
- wrt_en, inc_en, rst_en  out  NREG  one-hot (rst_en may be all-ones) register controls.
- busy  out  1  waiting on a memory acknowledge.
- halted  out  1  in HALT.
- fault  out  1  acknowledge timeout occurred (sticky).

## Operation
- Opcodes:
  - 0 NOP, 1 HALT, 2 LOAD, 3 STORE, 4 JMP, 5 JZ1, 6 JZ2, 7 INC, 8 CLR, 9 MOV.
  - 10–15 are ALU ops with alu_op = opcode−10.
- States:
  - INIT: pc_ctrl=11, rst_en all-ones. Goes to FETCH.
  - FETCH: imem_rd=1, busy=1. On iacq, IR<=ins and go to DECODE.
  - DECODE: all controls 0. LOAD/STORE go to MEM. HALT goes to HALT. Everything else goes to EXEC.
  - MEM: dmem_rd (LOAD) or dmem_wr (STORE) =1, busy=1, bus_sel=reg. On dacq, go to EXEC.
  - EXEC: one cycle of enables, then FETCH.
  - HALT: all controls 0, halted=1. Left only by reset.
  - FAULT: all controls 0, fault=1. Left only by reset.
- EXEC actions (r = register field):
  - NOP/STORE: pc_ctrl=01.
  - LOAD: wrt_en[r], pc_ctrl=01.
  - JMP: pc_ctrl=10.
  - JZ1/JZ2: pc_ctrl=10 if the flag is 1, else 01.
  - INC: inc_en[r]. CLR: rst_en[r]. MOV and ALU ops: bus_sel=r and wrt_en[0] (accumulator). All three use pc_ctrl=01.
  - ALU ops also drive alu_op.
- Register field r ≥ NREG: no enable asserted, bus_sel=0, pc_ctrl still 01. This is not a fault.
- All controls are 0 in any state/opcode not listed.
- Timeout:
  - A counter clears on entry to FETCH or MEM and increments each cycle without acknowledge.
  - When it reaches ACK_TIMEOUT−1 with no ack, the next state is FAULT.
  - Ack arriving in that same cycle wins.
  - ACK_TIMEOUT=0 waits forever.

## Timing
- Outputs are combinational from state, IR and flags. The state register and IR are the only sequential elements besides the timer.
- While rst_n is low: state=INIT, IR=0, counter=0. Outputs are pc_ctrl=11, rst_en all-ones, all others 0.
- First rising edge after release goes to FETCH.
- iacq high on the first FETCH cycle gives the minimum latency: 3 cycles per instruction for non-memory ops, 4 for LOAD/STORE. Each extra ack-wait cycle adds 1.
- Enables are single-cycle pulses in EXEC only.
- iacq outside FETCH and dacq outside MEM are ignored.
- z1/z2 are sampled only in the EXEC cycle.
- Reset asserted mid-instruction aborts immediately to INIT and clears fault.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams
  - state enum (INIT, FETCH, DECODE, MEM, EXEC, HALT, FAULT)
  - pc_ctrl encodings
- Sub-module ack_timer: parametrised by ACK_TIMEOUT, with clear/enable inputs and an expired output.

## Test plan
Defaults: INS_W=8, NREG=14, ACK_TIMEOUT=8.
- Reset, then release:
  - During reset: pc_ctrl=11 and rst_en=14'h3FFF.
  - Next cycle: imem_rd=1, all enables 0.
- ins=8'h73 with iacq immediate → exactly one cycle of inc_en=14'h0008 with pc_ctrl=01, 2 cycles after iacq.
- ins=8'h55:
  - z1=1 in EXEC → pc_ctrl=10.
  - Repeat with z1=0 → pc_ctrl=01.
- ins=8'h24 (LOAD r4) with dacq delayed 3 cycles:
  - dmem_rd=1 and busy=1 for 4 cycles.
  - Then wrt_en=14'h0010 for one cycle.
- ins=8'hC2 (ALU op 2) → alu_op=2, bus_sel=2, wrt_en=14'h0001. Then ins=8'h7F (r=15 ≥ NREG) → no enables, pc_ctrl=01.
- Hold iacq=0 for 8 cycles → fault=1 from cycle 9, all controls 0. Then rst_n pulse → fault=0, INIT.
- ins=8'h10 (HALT) → halted=1 permanently; iacq toggling has no effect.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcode map, FSM states and
// program-counter control encodings.
package ctrl_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP      = 4'd0;
  localparam logic [OP_W-1:0] OP_HALT     = 4'd1;
  localparam logic [OP_W-1:0] OP_LOAD     = 4'd2;
  localparam logic [OP_W-1:0] OP_STORE    = 4'd3;
  localparam logic [OP_W-1:0] OP_JMP      = 4'd4;
  localparam logic [OP_W-1:0] OP_JZ1      = 4'd5;
  localparam logic [OP_W-1:0] OP_JZ2      = 4'd6;
  localparam logic [OP_W-1:0] OP_INC      = 4'd7;
  localparam logic [OP_W-1:0] OP_CLR      = 4'd8;
  localparam logic [OP_W-1:0] OP_MOV      = 4'd9;
  localparam logic [OP_W-1:0] OP_ALU_BASE = 4'd10;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_EXEC,
    ST_HALT,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'b00,
    PC_INC   = 2'b01,
    PC_LOAD  = 2'b10,
    PC_RESET = 2'b11
  } pc_ctrl_t;

  // Opcodes 10..15 select the ALU; the ALU function is the offset from 10.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return op >= OP_ALU_BASE;
  endfunction

  function automatic logic [2:0] alu_code(input logic [OP_W-1:0] op);
    logic [OP_W-1:0] diff;
    diff = op - OP_ALU_BASE;
    return diff[2:0];
  endfunction

endpackage

// File: rtl/ctrl_sequencer_ack_timer.sv
// Acknowledge watchdog: counts cycles spent waiting for a memory acknowledge
// and flags the cycle in which the wait budget runs out.
module ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] count;

  // Wait counter: cleared outside the wait states, stepped on each un-acked cycle.
  // NOTE: clocked state uses non-blocking (<=) so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // A zero budget means wait forever; an ack (enable low) in the last cycle wins.
  assign expired = (ACK_TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: fetch over an ack handshake, decode, optional
// data-memory phase, then a single execute cycle of register/PC enables.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int INS_W       = 8,
  parameter int NREG        = 14,
  parameter int REG_W       = $clog2(NREG),
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INS_W-1:0] ins,
  input  logic             iacq,
  input  logic             dacq,
  input  logic             z1,
  input  logic             z2,
  output logic             imem_rd,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic [2:0]       alu_op,
  output logic [REG_W-1:0] bus_sel,
  output logic [1:0]       pc_ctrl,
  output logic [NREG-1:0]  wrt_en,
  output logic [NREG-1:0]  inc_en,
  output logic [NREG-1:0]  rst_en,
  output logic             busy,
  output logic             halted,
  output logic             fault
);

  localparam logic [REG_W:0] NREG_C = (REG_W + 1)'(NREG);

  state_t           state;
  state_t           state_nxt;
  pc_ctrl_t         pc_sel;
  logic [INS_W-1:0] ir;
  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] reg_f;
  logic             reg_ok;
  logic [REG_W-1:0] reg_bus;
  logic [NREG-1:0]  reg_onehot;
  logic             waiting;
  logic             acked;
  logic             expired;

  assign opcode     = ir[INS_W-1:INS_W-4];
  assign reg_f      = ir[REG_W-1:0];
  // Out-of-range register fields simply select nothing.
  assign reg_ok     = {1'b0, reg_f} < NREG_C;
  assign reg_bus    = reg_ok ? reg_f : '0;
  assign reg_onehot = reg_ok ? (NREG'(1) << reg_f) : '0;

  assign waiting = (state == ST_FETCH) || (state == ST_MEM);
  assign acked   = ((state == ST_FETCH) && iacq) || ((state == ST_MEM) && dacq);

  ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!waiting),
    .enable  (waiting && !acked),
    .expired (expired)
  );

  // State register and instruction register; IR loads on the fetch handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_FETCH) && iacq) begin
        ir <= ins;
      end
    end
  end

  // Next-state and control decode from state, IR and the zero flags.
  // NOTE: every output and the next state get a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    pc_sel    = PC_HOLD;
    imem_rd   = 1'b0;
    dmem_rd   = 1'b0;
    dmem_wr   = 1'b0;
    alu_op    = '0;
    bus_sel   = '0;
    wrt_en    = '0;
    inc_en    = '0;
    rst_en    = '0;
    busy      = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;

    unique case (state)
      ST_INIT: begin
        pc_sel    = PC_RESET;
        rst_en    = '1;
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        imem_rd = 1'b1;
        busy    = 1'b1;
        if (iacq)         state_nxt = ST_DECODE;
        else if (expired) state_nxt = ST_FAULT;
      end

      ST_DECODE: begin
        if ((opcode == OP_LOAD) || (opcode == OP_STORE)) state_nxt = ST_MEM;
        else if (opcode == OP_HALT)                      state_nxt = ST_HALT;
        else                                             state_nxt = ST_EXEC;
      end

      ST_MEM: begin
        busy    = 1'b1;
        bus_sel = reg_bus;
        if (opcode == OP_LOAD) dmem_rd = 1'b1;
        else                   dmem_wr = 1'b1;
        if (dacq)         state_nxt = ST_EXEC;
        else if (expired) state_nxt = ST_FAULT;
      end

      ST_EXEC: begin
        state_nxt = ST_FETCH;
        pc_sel    = PC_INC;
        case (opcode)
          OP_LOAD: wrt_en = reg_onehot;
          OP_JMP:  pc_sel = PC_LOAD;
          OP_JZ1:  pc_sel = z1 ? PC_LOAD : PC_INC;
          OP_JZ2:  pc_sel = z2 ? PC_LOAD : PC_INC;
          OP_INC:  inc_en = reg_onehot;
          OP_CLR:  rst_en = reg_onehot;
          OP_MOV: begin
            bus_sel = reg_bus;
            wrt_en  = reg_ok ? NREG'(1) : '0;
          end
          default: begin
            if (is_alu_op(opcode)) begin
              alu_op  = alu_code(opcode);
              bus_sel = reg_bus;
              wrt_en  = reg_ok ? NREG'(1) : '0;
            end
          end
        endcase
      end

      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;

      default: state_nxt = ST_INIT;
    endcase
  end

  assign pc_ctrl = pc_sel;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: a vector table of single instructions
// plus hand-written sequences for timeout, mid-instruction reset and HALT.
module tb_ctrl_sequencer;

  localparam int INS_W = 8;
  localparam int NREG  = 14;
  localparam int REG_W = 4;

  logic             clk;
  logic             rst_n;
  logic [INS_W-1:0] ins;
  logic             iacq, dacq, z1, z2;
  logic             imem_rd, dmem_rd, dmem_wr;
  logic [2:0]       alu_op;
  logic [REG_W-1:0] bus_sel;
  logic [1:0]       pc_ctrl;
  logic [NREG-1:0]  wrt_en, inc_en, rst_en;
  logic             busy, halted, fault;

  int n_checks = 0;
  int n_pass   = 0;

  ctrl_sequencer #(
    .INS_W       (INS_W),
    .NREG        (NREG),
    .REG_W       (REG_W),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ins     (ins),
    .iacq    (iacq),
    .dacq    (dacq),
    .z1      (z1),
    .z2      (z2),
    .imem_rd (imem_rd),
    .dmem_rd (dmem_rd),
    .dmem_wr (dmem_wr),
    .alu_op  (alu_op),
    .bus_sel (bus_sel),
    .pc_ctrl (pc_ctrl),
    .wrt_en  (wrt_en),
    .inc_en  (inc_en),
    .rst_en  (rst_en),
    .busy    (busy),
    .halted  (halted),
    .fault   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             imem_rd, dmem_rd, dmem_wr;
    logic [2:0]       alu;
    logic [REG_W-1:0] bus;
    logic [1:0]       pc;
    logic [NREG-1:0]  wrt, inc, rst;
    logic             busy, halted, fault;
  } exp_t;

  typedef struct {
    logic [INS_W-1:0] ins;
    int               iwait;
    int               dwait;
    logic             z1, z2;
    logic             is_mem, mem_rd;
    logic [REG_W-1:0] mem_bus;
    logic [NREG-1:0]  wrt, inc, rst;
    logic [2:0]       alu;
    logic [REG_W-1:0] bus;
    logic [1:0]       pc;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.imem_rd = 1'b0; e.dmem_rd = 1'b0; e.dmem_wr = 1'b0;
    e.alu = '0; e.bus = '0; e.pc = '0;
    e.wrt = '0; e.inc = '0; e.rst = '0;
    e.busy = 1'b0; e.halted = 1'b0; e.fault = 1'b0;
    return e;
  endfunction

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, " imem_rd"}, 32'(imem_rd), 32'(e.imem_rd));
    check({tag, " dmem_rd"}, 32'(dmem_rd), 32'(e.dmem_rd));
    check({tag, " dmem_wr"}, 32'(dmem_wr), 32'(e.dmem_wr));
    check({tag, " alu_op"},  32'(alu_op),  32'(e.alu));
    check({tag, " bus_sel"}, 32'(bus_sel), 32'(e.bus));
    check({tag, " pc_ctrl"}, 32'(pc_ctrl), 32'(e.pc));
    check({tag, " wrt_en"},  32'(wrt_en),  32'(e.wrt));
    check({tag, " inc_en"},  32'(inc_en),  32'(e.inc));
    check({tag, " rst_en"},  32'(rst_en),  32'(e.rst));
    check({tag, " busy"},    32'(busy),    32'(e.busy));
    check({tag, " halted"},  32'(halted),  32'(e.halted));
    check({tag, " fault"},   32'(fault),   32'(e.fault));
  endtask

  function automatic vec_t mk(
    input logic [INS_W-1:0] i, input int iw, input int dw, input logic a, input logic b,
    input logic m, input logic mr, input logic [REG_W-1:0] mb,
    input logic [NREG-1:0] w, input logic [NREG-1:0] n, input logic [NREG-1:0] r,
    input logic [2:0] al, input logic [REG_W-1:0] bs, input logic [1:0] p);
    vec_t v;
    v.ins = i; v.iwait = iw; v.dwait = dw; v.z1 = a; v.z2 = b;
    v.is_mem = m; v.mem_rd = mr; v.mem_bus = mb;
    v.wrt = w; v.inc = n; v.rst = r; v.alu = al; v.bus = bs; v.pc = p;
    return v;
  endfunction

  // Runs one instruction from a FETCH cycle through EXEC; returns in the next FETCH.
  task automatic run_vec(input int idx);
    vec_t  v;
    exp_t  e;
    string t;
    v  = vecs[idx];
    z1 = v.z1;
    z2 = v.z2;
    for (int k = 0; k <= v.iwait; k++) begin
      t = $sformatf("v%0d fetch%0d", idx, k);
      e = zero_exp(); e.imem_rd = 1'b1; e.busy = 1'b1;
      check_outs(t, e);
      ins  = v.ins;
      iacq = (k == v.iwait);
      dacq = 1'b1;
      @(negedge clk);
    end
    iacq = 1'b0;
    dacq = 1'b0;
    ins  = ~v.ins;
    check_outs($sformatf("v%0d decode", idx), zero_exp());
    @(negedge clk);
    if (v.is_mem) begin
      for (int k = 0; k <= v.dwait; k++) begin
        t = $sformatf("v%0d mem%0d", idx, k);
        e = zero_exp(); e.busy = 1'b1; e.bus = v.mem_bus;
        e.dmem_rd = v.mem_rd; e.dmem_wr = !v.mem_rd;
        check_outs(t, e);
        dacq = (k == v.dwait);
        iacq = 1'b1;
        @(negedge clk);
      end
      dacq = 1'b0;
      iacq = 1'b0;
    end
    e = zero_exp();
    e.wrt = v.wrt; e.inc = v.inc; e.rst = v.rst;
    e.alu = v.alu; e.bus = v.bus; e.pc = v.pc;
    check_outs($sformatf("v%0d exec", idx), e);
    iacq = 1'b1;
    @(negedge clk);
    iacq = 1'b0;
  endtask

  task automatic fetch_ack(input logic [INS_W-1:0] i);
    ins  = i;
    iacq = 1'b1;
    @(negedge clk);
    iacq = 1'b0;
  endtask

  task automatic reset_pulse(input string tag);
    exp_t e;
    rst_n = 1'b0;
    #1;
    e = zero_exp(); e.pc = 2'b11; e.rst = '1;
    check_outs(tag, e);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    //             ins    iw dw z1 z2 mem rd bus   wrt       inc       rst       alu bus pc
    vecs[0]  = mk(8'h73, 0, 0, 0, 0, 0, 0, 0, 14'h0000, 14'h0008, 14'h0000, 0, 0,  2'b01);
    vecs[1]  = mk(8'h55, 0, 0, 1, 0, 0, 0, 0, 14'h0000, 14'h0000, 14'h0000, 0, 0,  2'b10);
    vecs[2]  = mk(8'h55, 1, 0, 0, 1, 0, 0, 0, 14'h0000, 14'h0000, 14'h0000, 0, 0,  2'b01);
    vecs[3]  = mk(8'h65, 0, 0, 1, 0, 0, 0, 0, 14'h0000, 14'h0000, 14'h0000, 0, 0,  2'b01);
    vecs[4]  = mk(8'h65, 2, 0, 0, 1, 0, 0, 0, 14'h0000, 14'h0000, 14'h0000, 0, 0,  2'b10);
    vecs[5]  = mk(8'h24, 0, 3, 0, 0, 1, 1, 4, 14'h0010, 14'h0000, 14'h0000, 0, 0,  2'b01);
    vecs[6]  = mk(8'hC2, 0, 0, 0, 0, 0, 0, 0, 14'h0001, 14'h0000, 14'h0000, 2, 2,  2'b01);
    vecs[7]  = mk(8'h7F, 0, 0, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 14'h0000, 0, 0,  2'b01);
    vecs[8]  = mk(8'h3A, 0, 0, 0, 0, 1, 0, 10, 14'h0000, 14'h0000, 14'h0000, 0, 0, 2'b01);
    vecs[9]  = mk(8'h40, 7, 0, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 14'h0000, 0, 0,  2'b10);
    vecs[10] = mk(8'h8D, 0, 0, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 14'h2000, 0, 0,  2'b01);
    vecs[11] = mk(8'h9E, 0, 0, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 14'h0000, 0, 0,  2'b01);
    vecs[12] = mk(8'h9D, 0, 0, 0, 0, 0, 0, 0, 14'h0001, 14'h0000, 14'h0000, 0, 13, 2'b01);
    vecs[13] = mk(8'hF1, 0, 0, 0, 0, 0, 0, 0, 14'h0001, 14'h0000, 14'h0000, 5, 1,  2'b01);
    vecs[14] = mk(8'h2F, 0, 7, 0, 0, 1, 1, 0, 14'h0000, 14'h0000, 14'h0000, 0, 0,  2'b01);
    vecs[15] = mk(8'h00, 2, 0, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 14'h0000, 0, 0,  2'b01);
    vecs[16] = mk(8'h8E, 0, 0, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 14'h0000, 0, 0,  2'b01);

    rst_n = 1'b0; ins = '0; iacq = 1'b0; dacq = 1'b0; z1 = 1'b0; z2 = 1'b0;
    repeat (3) @(negedge clk);
    e = zero_exp(); e.pc = 2'b11; e.rst = 14'h3FFF;
    check_outs("reset", e);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Reset in the middle of a LOAD memory phase aborts straight to INIT.
    fetch_ack(8'h24);
    @(negedge clk);
    check("abort mem dmem_rd", 32'(dmem_rd), 32'd1);
    reset_pulse("abort reset");
    e = zero_exp(); e.imem_rd = 1'b1; e.busy = 1'b1;
    check_outs("abort refetch", e);

    // Instruction fetch timeout: eight un-acked FETCH cycles, FAULT on the ninth.
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ito%0d fault", k), 32'(fault), 32'd0);
      check($sformatf("ito%0d imem_rd", k), 32'(imem_rd), 32'd1);
      iacq = 1'b0;
      @(negedge clk);
    end
    e = zero_exp(); e.fault = 1'b1;
    check_outs("ifault", e);
    for (int k = 0; k < 4; k++) begin
      iacq = k[0];
      dacq = !k[0];
      @(negedge clk);
      check($sformatf("ifault hold%0d", k), 32'(fault), 32'd1);
    end
    iacq = 1'b0; dacq = 1'b0;
    reset_pulse("ifault reset");
    e = zero_exp(); e.imem_rd = 1'b1; e.busy = 1'b1;
    check_outs("ifault refetch", e);

    // Data-memory timeout during a STORE.
    fetch_ack(8'h3A);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("dto%0d dmem_wr", k), 32'(dmem_wr), 32'd1);
      check($sformatf("dto%0d fault", k), 32'(fault), 32'd0);
      dacq = 1'b0;
      @(negedge clk);
    end
    e = zero_exp(); e.fault = 1'b1;
    check_outs("dfault", e);
    reset_pulse("dfault reset");

    // HALT is terminal; acknowledges are ignored.
    fetch_ack(8'h10);
    check_outs("halt decode", zero_exp());
    @(negedge clk);
    e = zero_exp(); e.halted = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check_outs($sformatf("halt%0d", k), e);
      iacq = !k[0];
      dacq = k[0];
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
